// File: rtl/ocx_tlx_data_fifo_pkg.sv
// Shared defaults and channel indices for the TLX receive data FIFO.
package ocx_tlx_data_fifo_pkg;

  localparam int DEF_DATA_W   = 512;
  localparam int DEF_RD_CNT_W = 3;
  localparam int DEF_PEND_W   = 6;

  localparam int CH_RESP = 0;
  localparam int CH_CMD  = 1;

endpackage

// File: rtl/ocx_tlx_data_fifo_ch.sv
// One TLX data channel: CRC-speculative FIFO, pending-read counter and output register.
// Optional per-entry BDI storage when TLX_DATA_FIFO_BDI_EN is defined.
module ocx_tlx_data_fifo_ch
  import ocx_tlx_data_fifo_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_CNT_W = DEF_RD_CNT_W,
  parameter int PEND_W   = DEF_PEND_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_v,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_bdi,
  input  logic                good_crc,
  input  logic                crc_error,
  input  logic                rd_req,
  input  logic [RD_CNT_W-1:0] rd_cnt,
  output logic                rd_data_v,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_bdi,
  output logic                credit_v,
  output logic                fifo_full,
  output logic                err_overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_OCC = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

  logic [ADDR_W:0]   wr_ptr, commit_ptr, rd_ptr, wr_ptr_inc;
  logic [PEND_W-1:0] pending;
  logic [PEND_W:0]   pend_sum;
  logic              full, do_wr, do_pop, req_ovf;
  logic [DATA_W-1:0] mem [DEPTH];

  // Fullness uses the speculative wr_ptr; readability uses only committed data.
  assign full       = (wr_ptr - rd_ptr) == FULL_OCC;
  assign do_wr      = wr_v & ~full & ~crc_error;
  assign do_pop     = (pending != '0) && (rd_ptr != commit_ptr);
  assign wr_ptr_inc = wr_ptr + (ADDR_W+1)'(do_wr);
  assign fifo_full  = full;

  always_comb begin
    pend_sum = {1'b0, pending} - (PEND_W+1)'(do_pop);
    if (rd_req) pend_sum = pend_sum + (PEND_W+1)'(rd_cnt);
  end

  assign req_ovf = pend_sum > PEND_MAX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      rd_ptr       <= '0;
      pending      <= '0;
      err_overflow <= 1'b0;
      rd_data_v    <= 1'b0;
      credit_v     <= 1'b0;
      rd_data      <= '0;
    end else begin
      // crc_error rolls back and overrides a simultaneous good_crc.
      if (crc_error) begin
        wr_ptr <= commit_ptr;
      end else begin
        wr_ptr <= wr_ptr_inc;
        if (good_crc) commit_ptr <= wr_ptr_inc;
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[ADDR_W-1:0]];
      end
      pending   <= req_ovf ? PEND_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];
      rd_data_v <= do_pop;
      credit_v  <= do_pop;
      if ((wr_v && full) || req_ovf) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

`ifdef TLX_DATA_FIFO_BDI_EN
  logic bdi_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (do_wr) bdi_mem[wr_ptr[ADDR_W-1:0]] <= wr_bdi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_bdi <= 1'b0;
    else if (do_pop) rd_bdi <= bdi_mem[rd_ptr[ADDR_W-1:0]];
  end
`else
  logic unused_bdi;
  assign unused_bdi = wr_bdi;
  assign rd_bdi     = 1'b0;
`endif

endmodule

// File: rtl/ocx_tlx_data_fifo_mc.sv
// Multi-channel TLX receive data buffer: slices flattened buses onto per-channel FIFOs.
// BDI storage is built only when TLX_DATA_FIFO_BDI_EN is defined.
module ocx_tlx_data_fifo_mc
  import ocx_tlx_data_fifo_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_CNT_W = DEF_RD_CNT_W,
  parameter int PEND_W   = DEF_PEND_W
) (
  input  logic                       tlx_clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          wr_v,
  input  logic [NUM_CH*DATA_W-1:0]   wr_data,
  input  logic [NUM_CH-1:0]          wr_bdi,
  input  logic                       good_crc,
  input  logic                       crc_error,
  input  logic [NUM_CH-1:0]          rd_req,
  input  logic [NUM_CH*RD_CNT_W-1:0] rd_cnt,
  output logic [NUM_CH-1:0]          rd_data_v,
  output logic [NUM_CH*DATA_W-1:0]   rd_data,
  output logic [NUM_CH-1:0]          rd_bdi,
  output logic [NUM_CH-1:0]          credit_v,
  output logic [NUM_CH-1:0]          fifo_full,
  output logic [NUM_CH-1:0]          err_overflow
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ocx_tlx_data_fifo_ch #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .RD_CNT_W(RD_CNT_W),
      .PEND_W  (PEND_W)
    ) u_ch (
      .clk         (tlx_clk),
      .rst         (reset),
      .wr_v        (wr_v[c]),
      .wr_data     (wr_data[c*DATA_W +: DATA_W]),
      .wr_bdi      (wr_bdi[c]),
      .good_crc    (good_crc),
      .crc_error   (crc_error),
      .rd_req      (rd_req[c]),
      .rd_cnt      (rd_cnt[c*RD_CNT_W +: RD_CNT_W]),
      .rd_data_v   (rd_data_v[c]),
      .rd_data     (rd_data[c*DATA_W +: DATA_W]),
      .rd_bdi      (rd_bdi[c]),
      .credit_v    (credit_v[c]),
      .fifo_full   (fifo_full[c]),
      .err_overflow(err_overflow[c])
    );
  end

endmodule

// File: tb/tb_ocx_tlx_data_fifo_mc.sv
// Directed bench for ocx_tlx_data_fifo_mc (ADDR_W=3) with a read-data scoreboard.
module tb_ocx_tlx_data_fifo_mc;
  import ocx_tlx_data_fifo_pkg::*;

  localparam int NUM_CH   = 2;
  localparam int ADDR_W   = 3;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int DATA_W   = 64;
  localparam int RD_CNT_W = 3;
  localparam int PEND_W   = 6;
  localparam int W        = DATA_W + 1;

  logic                       tlx_clk = 1'b0;
  logic                       reset   = 1'b1;
  logic [NUM_CH-1:0]          wr_v    = '0;
  logic [NUM_CH*DATA_W-1:0]   wr_data = '0;
  logic [NUM_CH-1:0]          wr_bdi  = '0;
  logic                       good_crc  = 1'b0;
  logic                       crc_error = 1'b0;
  logic [NUM_CH-1:0]          rd_req  = '0;
  logic [NUM_CH*RD_CNT_W-1:0] rd_cnt  = '0;
  logic [NUM_CH-1:0]          rd_data_v;
  logic [NUM_CH*DATA_W-1:0]   rd_data;
  logic [NUM_CH-1:0]          rd_bdi;
  logic [NUM_CH-1:0]          credit_v;
  logic [NUM_CH-1:0]          fifo_full;
  logic [NUM_CH-1:0]          err_overflow;

  // clock / reset
  always #5 tlx_clk = ~tlx_clk;

  ocx_tlx_data_fifo_mc #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_CNT_W(RD_CNT_W), .PEND_W(PEND_W)
  ) dut (
    .tlx_clk(tlx_clk), .reset(reset), .wr_v(wr_v), .wr_data(wr_data),
    .wr_bdi(wr_bdi), .good_crc(good_crc), .crc_error(crc_error),
    .rd_req(rd_req), .rd_cnt(rd_cnt), .rd_data_v(rd_data_v),
    .rd_data(rd_data), .rd_bdi(rd_bdi), .credit_v(credit_v),
    .fifo_full(fifo_full), .err_overflow(err_overflow)
  );

  // scoreboard state: committed (exp_q) and speculative (unc_q) flits, {bdi, data}
  logic [W-1:0]      exp_q [NUM_CH][$];
  logic [W-1:0]      unc_q [NUM_CH][$];
  logic [NUM_CH-1:0] exp_err = '0;
  int                n_checks = 0;
  int                n_errors = 0;
  int                reads_seen   [NUM_CH];
  int                credits_seen [NUM_CH];
  logic [W-1:0]      mon_e;
  logic              mon_bdi;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // output monitor: pops the scoreboard on each rd_data_v
  always @(negedge tlx_clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (credit_v[c]) credits_seen[c]++;
        if (rd_data_v[c] || credit_v[c])
          chk($sformatf("credit_v_ch%0d", c), 64'(credit_v[c]), 64'(rd_data_v[c]));
        if (rd_data_v[c]) begin
          reads_seen[c]++;
          if (exp_q[c].size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL unexp_read_ch%0d: observed data %h expected no read",
                   c, rd_data[c*DATA_W +: DATA_W]);
          end else begin
            mon_e = exp_q[c].pop_front();
`ifdef TLX_DATA_FIFO_BDI_EN
            mon_bdi = mon_e[DATA_W];
`else
            mon_bdi = 1'b0;
`endif
            chk($sformatf("rd_data_ch%0d", c), rd_data[c*DATA_W +: DATA_W], mon_e[DATA_W-1:0]);
            chk($sformatf("rd_bdi_ch%0d", c), 64'(rd_bdi[c]), 64'(mon_bdi));
          end
        end
      end
    end
  end

  // driver: one cycle of stimulus; model updated as the stimulus is applied
  task automatic drive(input int c, input logic v, input logic [DATA_W-1:0] d,
                       input logic bdi, input logic gc, input logic ce,
                       input logic rq, input logic [RD_CNT_W-1:0] n);
    if (v) begin
      if (unc_q[c].size() + exp_q[c].size() >= DEPTH) exp_err[c] = 1'b1;
      else if (!ce) unc_q[c].push_back({bdi, d});
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (ce) unc_q[k].delete();
      else if (gc) while (unc_q[k].size() > 0) exp_q[k].push_back(unc_q[k].pop_front());
    end
    wr_v[c] = v;
    wr_data[c*DATA_W +: DATA_W] = d;
    wr_bdi[c] = bdi;
    good_crc  = gc;
    crc_error = ce;
    rd_req[c] = rq;
    rd_cnt[c*RD_CNT_W +: RD_CNT_W] = n;
    @(posedge tlx_clk);
    #1;
    wr_v = '0; wr_data = '0; wr_bdi = '0; good_crc = 1'b0; crc_error = 1'b0;
    rd_req = '0; rd_cnt = '0;
  endtask

  task automatic wr(input int c, input logic [DATA_W-1:0] d, input logic bdi);
    drive(c, 1'b1, d, bdi, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic commit();
    drive(0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input int c, input logic [RD_CNT_W-1:0] n);
    drive(c, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, n);
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge tlx_clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int c = 0; c < NUM_CH; c++) begin
      reads_seen[c] = 0;
      credits_seen[c] = 0;
    end
  endtask

  // bounded wait for the monitor to see `target` reads on channel c
  task automatic wait_reads(input int c, input int target, input string tag);
    for (int i = 0; i < 60 && reads_seen[c] < target; i++) @(posedge tlx_clk);
    chk(tag, 64'(reads_seen[c]), 64'(target));
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    clr_counts();
    repeat (3) @(posedge tlx_clk);
    #1;
    chk("rst_rd_data_v", 64'(rd_data_v), 64'(0));
    chk("rst_credit_v", 64'(credit_v), 64'(0));
    chk("rst_fifo_full", 64'(fifo_full), 64'(0));
    chk("rst_err_overflow", 64'(err_overflow), 64'(0));
    chk("rst_rd_bdi", 64'(rd_bdi), 64'(0));
    reset = 1'b0;
    idle(2);

    // 1: three flits, commit, read 3 with one-cycle latency after the pop
    clr_counts();
    for (int i = 0; i < 3; i++) wr(CH_RESP, rnd(), 1'b0);
    commit();
    rd(CH_RESP, 3'd3);
    @(negedge tlx_clk);
    chk("t1_v_before_pop", 64'(rd_data_v[CH_RESP]), 64'(0));
    @(negedge tlx_clk);
    chk("t1_v_after_pop", 64'(rd_data_v[CH_RESP]), 64'(1));
    wait_reads(CH_RESP, 3, "t1_reads");
    idle(3);
    chk("t1_credits", 64'(credits_seen[CH_RESP]), 64'(3));

    // 2: rollback discards C,D; reads A,B,E
    clr_counts();
    wr(CH_RESP, 64'hA, 1'b0);
    wr(CH_RESP, 64'hB, 1'b0);
    commit();
    wr(CH_RESP, 64'hC, 1'b0);
    wr(CH_RESP, 64'hD, 1'b0);
    drive(0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    wr(CH_RESP, 64'hE, 1'b0);
    commit();
    rd(CH_RESP, 3'd3);
    wait_reads(CH_RESP, 3, "t2_reads");
    idle(4);
    chk("t2_no_extra", 64'(reads_seen[CH_RESP]), 64'(3));

    // 3: fill ch1, overflow, drain, refill across the pointer wrap
    clr_counts();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t3_not_full_7", 64'(fifo_full[CH_CMD]), 64'(0));
      wr(CH_CMD, rnd(), 1'b0);
    end
    chk("t3_full_8", 64'(fifo_full[CH_CMD]), 64'(1));
    chk("t3_no_err_yet", 64'(err_overflow[CH_CMD]), 64'(exp_err[CH_CMD]));
    wr(CH_CMD, 64'hDEAD_BEEF, 1'b0);
    chk("t3_err_ch1", 64'(err_overflow[CH_CMD]), 64'(exp_err[CH_CMD]));
    chk("t3_err_ch0", 64'(err_overflow[CH_RESP]), 64'(exp_err[CH_RESP]));
    commit();
    rd(CH_CMD, 3'd7);
    rd(CH_CMD, 3'd1);
    wait_reads(CH_CMD, DEPTH, "t3_drain");
    chk("t3_not_full_drained", 64'(fifo_full[CH_CMD]), 64'(0));
    for (int r = 0; r < 2; r++) begin
      clr_counts();
      for (int i = 0; i < 6; i++) wr(CH_CMD, rnd(), 1'b0);
      commit();
      rd(CH_CMD, 3'd6);
      wait_reads(CH_CMD, 6, "t3_wrap_reads");
    end

    // 4: request on empty channel waits for commit; leftover pending serves the next flit
    clr_counts();
    rd(CH_RESP, 3'd2);
    wr(CH_RESP, 64'h1111, 1'b0);
    idle(4);
    chk("t4_uncommitted_hidden", 64'(reads_seen[CH_RESP]), 64'(0));
    commit();
    wait_reads(CH_RESP, 1, "t4_x_delivered");
    idle(3);
    chk("t4_one_read", 64'(reads_seen[CH_RESP]), 64'(1));
    drive(CH_RESP, 1'b1, 64'h2222, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    wait_reads(CH_RESP, 2, "t4_pending_left");

    // 5: good_crc + crc_error together drop the write and keep commit_ptr
    clr_counts();
    drive(CH_RESP, 1'b1, 64'h5A5A, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    rd(CH_RESP, 3'd1);
    idle(4);
    chk("t5_dropped", 64'(reads_seen[CH_RESP]), 64'(0));
    wr(CH_RESP, 64'h7777, 1'b0);
    commit();
    wait_reads(CH_RESP, 1, "t5_next_write");

    // 6a: BDI only on flit 2
    clr_counts();
    wr(CH_CMD, rnd(), 1'b0);
    wr(CH_CMD, rnd(), 1'b1);
    wr(CH_CMD, rnd(), 1'b0);
    commit();
    rd(CH_CMD, 3'd3);
    wait_reads(CH_CMD, 3, "t6_bdi_reads");

    // 6b: reset in the middle of a read burst
    clr_counts();
    for (int i = 0; i < 6; i++) wr(CH_CMD, rnd(), 1'b0);
    commit();
    rd(CH_CMD, 3'd6);
    wait_reads(CH_CMD, 2, "t6_burst_started");
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_rd_data_v", 64'(rd_data_v), 64'(0));
    chk("t6_rst_credit_v", 64'(credit_v), 64'(0));
    chk("t6_rst_rd_data0", rd_data[0 +: DATA_W], 64'(0));
    chk("t6_rst_rd_data1", rd_data[DATA_W +: DATA_W], 64'(0));
    chk("t6_rst_err", 64'(err_overflow), 64'(0));
    chk("t6_rst_full", 64'(fifo_full), 64'(0));
    for (int c = 0; c < NUM_CH; c++) begin
      exp_q[c].delete();
      unc_q[c].delete();
    end
    exp_err = '0;
    idle(2);
    reset = 1'b0;
    idle(1);
    clr_counts();
    wr(CH_CMD, 64'h0BAD_F00D, 1'b0);
    commit();
    idle(4);
    chk("t6_pending_cleared", 64'(reads_seen[CH_CMD]), 64'(0));
    rd(CH_CMD, 3'd1);
    wait_reads(CH_CMD, 1, "t6_after_reset_read");
    idle(3);
    chk("t6_single_read", 64'(reads_seen[CH_CMD]), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
